// File: rtl/interrupt_controller.sv
// Priority interrupt controller: edge-latched maskable requests (lowest index wins) plus one NMI
// that can preempt a pending request or nest one level inside an active maskable handler.
module interrupt_controller #(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned VEC_W   = 3
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_SRC-1:0] IRQ,
   input  logic               NMIReq,
   input  logic               INTD,
   input  logic               INA,
   input  logic               EOI,
   input  logic               MaskWe,
   input  logic [NUM_SRC-1:0] MaskIn,
   output logic               INT,
   output logic               NMI,
   output logic [VEC_W-1:0]   IntVector,
   output logic               InService,
   output logic [NUM_SRC-1:0] Pending
);

   typedef enum logic [2:0] {StIdle, StReq, StService, StNmiReq, StNmiService} state_e;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] irq_q, mask_q, pending_q, pending_d;
   logic [NUM_SRC-1:0] irq_rise, eligible, pend_clr;
   logic               nmi_req_q, nmi_rise, nmi_pend_q, nmi_pend_d, nmi_clr;
   logic               nest_q, nest_d;
   logic [VEC_W-1:0]   vec_q, vec_d, winner;
   logic               int_q, nmi_q, in_service_q;

   assign irq_rise = IRQ & ~irq_q;
   assign nmi_rise = NMIReq & ~nmi_req_q;
   assign eligible = pending_q & ~mask_q;

   // Descending scan so the lowest eligible index is the last one written.
   always_comb begin
      winner = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (eligible[i]) winner = VEC_W'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      nest_d   = nest_q;
      pend_clr = '0;
      nmi_clr  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (nmi_pend_q) begin
               state_d = StNmiReq;
               nest_d  = 1'b0;
            end else if ((|eligible) && !INTD) begin
               state_d = StReq;
               vec_d   = winner;
            end
         end
         StReq: begin
            if (INA) begin
               state_d  = StService;
               pend_clr = NUM_SRC'(1) << vec_q;
            end else if (nmi_pend_q) begin
               state_d = StNmiReq;
               nest_d  = 1'b0;
               vec_d   = '0;
            end else if (INTD) begin
               state_d = StIdle;
               vec_d   = '0;
            end
         end
         StService: begin
            if (EOI) begin
               state_d = StIdle;
               vec_d   = '0;
            end else if (nmi_pend_q) begin
               state_d = StNmiReq;
               nest_d  = 1'b1;
            end
         end
         StNmiReq: begin
            if (INA) begin
               state_d = StNmiService;
               nmi_clr = 1'b1;
            end
         end
         StNmiService: begin
            if (EOI) begin
               if (nest_q) begin
                  state_d = StService;
                  nest_d  = 1'b0;
               end else begin
                  state_d = StIdle;
                  vec_d   = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            vec_d   = '0;
            nest_d  = 1'b0;
         end
      endcase
      // A new edge in the same cycle as the acknowledge clear keeps the bit set.
      pending_d  = (pending_q & ~pend_clr) | irq_rise;
      nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_rise;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= StIdle;
         irq_q        <= '0;
         nmi_req_q    <= 1'b0;
         mask_q       <= '1;
         pending_q    <= '0;
         nmi_pend_q   <= 1'b0;
         nest_q       <= 1'b0;
         vec_q        <= '0;
         int_q        <= 1'b0;
         nmi_q        <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_q        <= IRQ;
         nmi_req_q    <= NMIReq;
         if (MaskWe) mask_q <= MaskIn;
         pending_q    <= pending_d;
         nmi_pend_q   <= nmi_pend_d;
         nest_q       <= nest_d;
         vec_q        <= vec_d;
         int_q        <= (state_d == StReq);
         nmi_q        <= (state_d == StNmiReq);
         // The maskable handler stays active while a nested NMI runs on top of it.
         in_service_q <= (state_d == StService) ||
                         (nest_d && (state_d == StNmiReq || state_d == StNmiService));
      end
   end

   assign INT       = int_q;
   assign NMI       = nmi_q;
   assign IntVector = vec_q;
   assign InService = in_service_q;
   assign Pending   = pending_q;

endmodule
